// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a start/busy/done handshake,
// carry and signed-overflow flags, and a multi-cycle shift-add multiplier.
// Optional restoring divider for op 111 is built when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ag,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_DIV = 3'b111
    } op_t;

`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_MUL} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc_nxt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   s_res;
    logic               s_carry;
    logic               s_ovf;
    logic               last_iter;

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
`endif

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Single-cycle result and flags from the live inputs (latched at acceptance)
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        s_res   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                s_res   = sum[WIDTH-1:0];
                s_carry = sum[WIDTH];
                s_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_res   = diff[WIDTH-1:0];
                s_carry = diff[WIDTH];
                s_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: s_res = a & b;
            OP_OR:  s_res = a | b;
            OP_XOR: s_res = a ^ b;
            OP_SLT: s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: s_res = '0;
        endcase
    end

    // One shift-add multiplier step
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

`ifdef ALU_SEQ_DIV_EN
    // One restoring-divide step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {1'b0, op_b};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // Control FSM, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
`ifdef ALU_SEQ_DIV_EN
            rem    <= '0;
            quo    <= '0;
`endif
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            ag     <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a <= a;
                        op_b <= b;
                        cnt  <= '0;
                        if (op_t'(op) == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            busy   <= 1'b1;
                            state  <= ST_MUL;
`ifdef ALU_SEQ_DIV_EN
                        end else if (op_t'(op) == OP_DIV) begin
                            rem   <= '0;
                            quo   <= a;
                            busy  <= 1'b1;
                            state <= ST_DIV;
`endif
                        end else begin
                            result <= s_res;
                            zero   <= (s_res == '0);
                            ag     <= (a > b);
                            carry  <= s_carry;
                            ovf    <= s_ovf;
                            done   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        result <= acc_nxt[WIDTH-1:0];
                        zero   <= (acc_nxt[WIDTH-1:0] == '0);
                        ag     <= (op_a > op_b);
                        carry  <= |acc_nxt[2*WIDTH-1:WIDTH];
                        ovf    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_IDLE;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        // divide-by-zero naturally yields an all-ones quotient
                        result <= quo_nxt;
                        zero   <= (quo_nxt == '0);
                        ag     <= (op_a > op_b);
                        carry  <= (op_b == '0);
                        ovf    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq (WIDTH=16)
// against an arithmetic reference model. Honors ALU_SEQ_DIV_EN.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         ag;
    logic         carry;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero),
        .ag     (ag),
        .carry  (carry),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output bit multi);
        int unsigned ux = x;
        int unsigned uy = y;
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int s;
        longint unsigned p;
        r = '0; c = 1'b0; v = 1'b0; multi = 0;
        case (o)
            3'd0: begin
                r = W'(ux + uy);
                c = (ux + uy) > 32'hFFFF;
                s = sx + sy;
                v = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                r = W'(ux - uy);
                c = ux < uy;
                s = sx - sy;
                v = (s > 32767) || (s < -32768);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = (sx < sy) ? 16'd1 : 16'd0;
            3'd6: begin
                p = longint'(ux) * longint'(uy);
                r = W'(p);
                c = (p >> W) != 0;
                multi = 1;
            end
            default: begin
`ifdef ALU_SEQ_DIV_EN
                multi = 1;
                if (uy == 0) begin
                    r = 16'hFFFF;
                    c = 1'b1;
                end else begin
                    r = W'(ux / uy);
                end
`else
                r = '0;
`endif
            end
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke);
        logic [W-1:0] er;
        logic         ec;
        logic         ev;
        bit           multi;
        int           n;
        int           busy_lo;
        model(o, x, y, er, ec, ev, multi);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        if (!multi) begin
            check("done_single", done, 1);
            check("busy_single", busy, 0);
        end else begin
            check("busy_accept", busy, 1);
            check("done_accept", done, 0);
            n = 1;
            busy_lo = 0;
            while (n <= W + 4) begin
                if (poke && n == 3) begin start = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0001; end
                if (poke && n == 6) start = 1'b0;
                @(posedge clk); #1;
                if (done) break;
                if (!busy) busy_lo++;
                n++;
            end
            check("latency", n, W);
            check("busy_held", busy_lo, 0);
            check("busy_end", busy, 0);
        end
        check("result", result, er);
        check("zero", zero, (er == '0));
        check("ag", ag, (x > y));
        check("carry", carry, ec);
        check("ovf", ovf, ev);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("result_hold", result, er);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_ag", ag, 0);
        check("rst_carry", carry, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 16'h7FFF, 16'h0001, 0);
        run_op(3'd1, 16'h0005, 16'h0005, 0);
        run_op(3'd1, 16'h0003, 16'h0005, 0);
        run_op(3'd5, 16'hFFFF, 16'h0001, 0);
        run_op(3'd2, 16'hF0F0, 16'h0FF0, 0);
        run_op(3'd6, 16'h0123, 16'h0010, 1);
        run_op(3'd6, 16'h8000, 16'h0002, 0);
        run_op(3'd7, 16'd100, 16'd7, 0);
        run_op(3'd7, 16'd100, 16'd0, 0);

        // Reset aborts a multiply in its 5th cycle
        op = 3'd6; a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 1);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(3'd0, 16'h1111, 16'h2222, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick(), pick(), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
